nc_ifetch_responder: RTL and testbench

- Responder end of the non-cacheable instruction-fetch bypass.
- Accepts the single-cycle nc fetch request from the core-side icache buffer, which carries a 40-bit, 8-byte-aligned address.
- Issues the read on the memory/NoC-side valid/ready port and assembles the 64-bit word from MEM_DATA_W beats.
- Returns exactly one grant pulse with 64-bit data for every accepted request, including on timeout, so the requester's wait/kill states always terminate.

---
 rtl/sargantana_icache_pkg.sv | 16 +
 rtl/nc_beat_assembler.sv | 52 +++++
 rtl/nc_ifetch_responder.sv | 114 +++++++++++
 tb/tb_nc_ifetch_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared types and widths for the non-cacheable instruction-fetch bypass.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sargantana_icache_pkg;

  localparam int NC_ADDR_W = 40;
  localparam int NC_WORD_W = 64;

  typedef enum logic [1:0] {
    NC_IDLE      = 2'd0,
    NC_SEND_REQ  = 2'd1,
    NC_WAIT_RESP = 2'd2,
    NC_GRANT     = 2'd3
  } nc_resp_state_t;

endpackage

// File: rtl/nc_beat_assembler.sv
// Packs MEM_DATA_W-wide response beats into one 64-bit word, beat 0 in the low bits.
// Latency: a beat is visible in word the cycle after it is accepted.
// Backpressure: none; every beat_valid is consumed.
//
// Ports: clk_i/rstn_i clock and async active-low reset; clear restarts a word;
// beat_valid/beat_data incoming beat; force_zero wipes the word (timeout);
// last_beat flags the completing beat combinationally; word is the assembled data.
module nc_beat_assembler
  import sargantana_icache_pkg::*;
#(
  parameter int MEM_DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [MEM_DATA_W-1:0] beat_data,
  input  logic                  force_zero,
  output logic                  last_beat,
  output logic [NC_WORD_W-1:0]  word
);

  localparam int NUM_BEATS = NC_WORD_W / MEM_DATA_W;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic [CNT_W-1:0]     beat_cnt;
  logic [NC_WORD_W-1:0] data_q;

  assign last_beat = beat_valid && (beat_cnt == CNT_W'(NUM_BEATS - 1));
  assign word      = data_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      beat_cnt <= '0;
      data_q   <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      data_q   <= '0;
    end else if (force_zero) begin
      data_q <= '0;
    end else if (beat_valid) begin
      // Constant-index slices keep the write in range for every legal width.
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (beat_cnt == CNT_W'(b)) begin
          data_q[b*MEM_DATA_W +: MEM_DATA_W] <= beat_data;
        end
      end
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nc_ifetch_responder.sv
// Responder for non-cacheable ifetch: one memory read per request, one grant per accepted request.
// Latency: req->mem_req_valid 1 cycle; final beat->grant 1 cycle (min turnaround 3 cycles).
// Backpressure: holds mem request until ready; requests arriving while busy are dropped (overrun_o).
//
// Ports: clk_i/rstn_i; req_nc_valid_i/req_nc_vaddr_i request pulse and address;
// l2_grant_valid_o/l2_resp_data_o grant pulse and word; mem_req_* read request;
// mem_resp_* response beats; busy_o; sticky timeout_o, overrun_o, stray_resp_o.
module nc_ifetch_responder
  import sargantana_icache_pkg::*;
#(
  parameter int MEM_DATA_W     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_W       = 11
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_nc_valid_i,
  input  logic [NC_ADDR_W-1:0]  req_nc_vaddr_i,
  output logic                  l2_grant_valid_o,
  output logic [NC_WORD_W-1:0]  l2_resp_data_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [NC_ADDR_W-1:0]  mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [MEM_DATA_W-1:0] mem_resp_data_i,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic                  overrun_o,
  output logic                  stray_resp_o
);

  localparam bit                  TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  nc_resp_state_t       state_q, state_d;
  logic [NC_ADDR_W-1:0] addr_q;
  logic [TO_CNT_W-1:0]  to_cnt_q;
  logic [NC_WORD_W-1:0] resp_q;
  logic [NC_WORD_W-1:0] word;
  logic                 accept, in_wait, beat_vld, last_beat, timeout_fire;
  logic                 timeout_q, overrun_q, stray_q;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^req_nc_vaddr_i[2:0];

  assign accept   = (state_q == NC_IDLE) && req_nc_valid_i;
  assign in_wait  = (state_q == NC_WAIT_RESP);
  assign beat_vld = in_wait && mem_resp_valid_i;
  // A final beat landing on the last allowed cycle wins over the timeout.
  assign timeout_fire = TO_EN && in_wait && (to_cnt_q == TO_LAST) && !last_beat;

  nc_beat_assembler #(.MEM_DATA_W(MEM_DATA_W)) u_asm (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clear      (accept),
    .beat_valid (beat_vld),
    .beat_data  (mem_resp_data_i),
    .force_zero (timeout_fire),
    .last_beat  (last_beat),
    .word       (word)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= NC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NC_IDLE:      if (req_nc_valid_i)              state_d = NC_SEND_REQ;
      NC_SEND_REQ:  if (mem_req_ready_i)             state_d = NC_WAIT_RESP;
      NC_WAIT_RESP: if (last_beat || timeout_fire)   state_d = NC_GRANT;
      NC_GRANT:                                      state_d = NC_IDLE;
      default:                                       state_d = NC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q    <= '0;
      to_cnt_q  <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= {req_nc_vaddr_i[NC_ADDR_W-1:3], 3'b000};
        to_cnt_q <= '0;
      end else if (in_wait) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      // Keeps the returned word on the output after the grant, even once a new request clears the assembler.
      if (state_q == NC_GRANT) resp_q <= word;
      if (timeout_fire) timeout_q <= 1'b1;
      if (req_nc_valid_i && (state_q != NC_IDLE)) overrun_q <= 1'b1;
      if (mem_resp_valid_i && !in_wait) stray_q <= 1'b1;
    end
  end

  assign l2_grant_valid_o = (state_q == NC_GRANT);
  assign l2_resp_data_o   = l2_grant_valid_o ? word : resp_q;
  assign mem_req_valid_o  = (state_q == NC_SEND_REQ);
  assign mem_req_addr_o   = addr_q;
  assign busy_o           = (state_q != NC_IDLE);
  assign timeout_o        = timeout_q;
  assign overrun_o        = overrun_q;
  assign stray_resp_o     = stray_q;

endmodule

// File: tb/tb_nc_ifetch_responder.sv
// Bench for nc_ifetch_responder: 32-bit-beat instance (timeout 8) and 64-bit-beat instance.
// Expected grant timing and data are derived per transaction from the request/beat schedule.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_nc_ifetch_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  // 32-bit beat instance
  logic        req_a = 0, ready_a = 0, rv_a = 0;
  logic [39:0] vaddr_a = '0;
  logic [31:0] rd_a = '0;
  logic        gv_a, mv_a, busy_a, to_a, ov_a, st_a;
  logic [63:0] data_a;
  logic [39:0] maddr_a;

  // 64-bit beat instance
  logic        req_b = 0, ready_b = 0, rv_b = 0;
  logic [39:0] vaddr_b = '0;
  logic [63:0] rd_b = '0;
  logic        gv_b, mv_b, busy_b, to_b, ov_b, st_b;
  logic [63:0] data_b;
  logic [39:0] maddr_b;

  nc_ifetch_responder #(.MEM_DATA_W(32), .TIMEOUT_CYCLES(8), .TO_CNT_W(4)) u_dut_a (
    .clk_i(clk), .rstn_i(rstn),
    .req_nc_valid_i(req_a), .req_nc_vaddr_i(vaddr_a),
    .l2_grant_valid_o(gv_a), .l2_resp_data_o(data_a),
    .mem_req_valid_o(mv_a), .mem_req_ready_i(ready_a), .mem_req_addr_o(maddr_a),
    .mem_resp_valid_i(rv_a), .mem_resp_data_i(rd_a),
    .busy_o(busy_a), .timeout_o(to_a), .overrun_o(ov_a), .stray_resp_o(st_a)
  );

  nc_ifetch_responder #(.MEM_DATA_W(64), .TIMEOUT_CYCLES(8), .TO_CNT_W(4)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .req_nc_valid_i(req_b), .req_nc_vaddr_i(vaddr_b),
    .l2_grant_valid_o(gv_b), .l2_resp_data_o(data_b),
    .mem_req_valid_o(mv_b), .mem_req_ready_i(ready_b), .mem_req_addr_o(maddr_b),
    .mem_resp_valid_i(rv_b), .mem_resp_data_i(rd_b),
    .busy_o(busy_b), .timeout_o(to_b), .overrun_o(ov_b), .stray_resp_o(st_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_to = 0, exp_ov = 0, exp_st = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_flags_a();
    chk("a_timeout_flag", to_a, exp_to);
    chk("a_overrun_flag", ov_a, exp_ov);
    chk("a_stray_flag",   st_a, exp_st);
  endtask

  // One transaction on the 32-bit instance, starting and ending on a falling edge in IDLE.
  // rd: cycles ready is held low; g0: idle WAIT cycles before beat 0; g1: gap between beats.
  // to_mode: memory never completes (at most one non-final beat), forcing a timeout grant.
  task automatic run_txn_a(input logic [39:0] a, input int rd, input int g0, input int g1,
                           input bit to_mode, input bit poke,
                           input logic [31:0] b0, input logic [31:0] b1);
    logic [39:0] exp_addr;
    logic [63:0] exp_data;
    int          g;
    exp_addr = {a[39:3], 3'b000};
    exp_data = to_mode ? 64'h0 : {b1, b0};
    // WAIT cycles are numbered from 1; the grant is seen one cycle after the completing cycle.
    g = to_mode ? 9 : g0 + g1 + 3;
    chk("a_idle_busy", busy_a, 1'b0);
    req_a = 1; vaddr_a = a;
    @(negedge clk);
    req_a = 0; vaddr_a = {8'($urandom), 32'($urandom)};
    for (int i = 0; i <= rd; i++) begin
      chk("a_req_vld", mv_a, 1'b1);
      chk("a_req_addr", maddr_a, exp_addr);
      ready_a = (i == rd);
      @(negedge clk);
    end
    ready_a = 0;
    for (int k = 1; k < g; k++) begin
      chk("a_no_grant", gv_a, 1'b0);
      chk("a_no_second_req", mv_a, 1'b0);
      if (poke && k == 1) begin
        req_a = 1; vaddr_a = {8'($urandom), 32'($urandom)}; exp_ov = 1;
      end
      if (k == g0 + 1) begin rv_a = 1; rd_a = b0; end
      if (!to_mode && k == g0 + g1 + 2) begin rv_a = 1; rd_a = b1; end
      @(negedge clk);
      req_a = 0; rv_a = 0;
    end
    chk("a_grant", gv_a, 1'b1);
    chk("a_grant_data", data_a, exp_data);
    if (to_mode) exp_to = 1;
    chk("a_timeout_flag", to_a, exp_to);
    @(negedge clk);
    chk("a_grant_pulse_end", gv_a, 1'b0);
    chk("a_data_hold", data_a, exp_data);
    chk("a_done_busy", busy_a, 1'b0);
    if (to_mode) begin
      rv_a = 1; rd_a = $urandom; exp_st = 1;
      @(negedge clk);
      rv_a = 0;
      chk("a_stray_data_kept", data_a, exp_data);
    end
    chk_flags_a();
  endtask

  // One transaction on the 64-bit instance with rd ready-low cycles and g idle WAIT cycles.
  task automatic run_txn_b(input logic [39:0] a, input int rd, input int g, input logic [63:0] d);
    req_b = 1; vaddr_b = a;
    @(negedge clk);
    req_b = 0;
    for (int i = 0; i <= rd; i++) begin
      chk("b_req_vld", mv_b, 1'b1);
      chk("b_req_addr", maddr_b, {a[39:3], 3'b000});
      ready_b = (i == rd);
      @(negedge clk);
    end
    ready_b = 0;
    for (int k = 0; k < g; k++) begin
      chk("b_no_grant", gv_b, 1'b0);
      @(negedge clk);
    end
    chk("b_no_grant_yet", gv_b, 1'b0);
    rv_b = 1; rd_b = d;
    @(negedge clk);
    rv_b = 0;
    chk("b_grant", gv_b, 1'b1);
    chk("b_grant_data", data_b, d);
    @(negedge clk);
    chk("b_grant_pulse_end", gv_b, 1'b0);
    chk("b_busy", busy_b, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_grant", gv_a, 1'b0);
    chk("rst_data", data_a, 64'h0);
    chk("rst_req_vld", mv_a, 1'b0);
    chk("rst_req_addr", maddr_a, 40'h0);
    chk("rst_busy", busy_a, 1'b0);
    chk_flags_a();
    rstn = 1;
    @(negedge clk);

    // Two beats with a 3-cycle gap
    run_txn_a(40'h12_3456_789C, 0, 0, 3, 0, 0, 32'h1111_1111, 32'h2222_2222);
    // Ready stalled 5 cycles, then no response: timeout counts only WAIT cycles
    run_txn_a(40'h00_4000_0010, 5, 2, 0, 1, 0, 32'hA5A5_A5A5, 32'h0);
    // Normal completion after a timeout
    run_txn_a(40'h00_4000_0018, 1, 1, 1, 0, 0, $urandom, $urandom);
    // Overrun while waiting for the response
    run_txn_a(40'hFF_FFFF_FFFF, 0, 2, 2, 0, 1, 32'hCAFE_0001, 32'hCAFE_0002);
    // Final beat on the last allowed WAIT cycle beats the timeout
    run_txn_a(40'h01_0000_0008, 2, 3, 3, 0, 0, 32'h0BAD_F00D, 32'h600D_CAFE);

    for (int n = 0; n < 40; n++) begin
      run_txn_a({8'($urandom), 32'($urandom)}, $urandom_range(3, 0),
                $urandom_range(3, 0), $urandom_range(3, 0),
                ($urandom_range(5, 0) == 0), ($urandom_range(3, 0) == 0),
                $urandom, $urandom);
    end

    // Reset while in WAIT_RESP
    req_a = 1; vaddr_a = 40'h00_0000_1230;
    @(negedge clk);
    req_a = 0; ready_a = 1;
    @(negedge clk);
    ready_a = 0;
    chk("a_pre_rst_busy", busy_a, 1'b1);
    rstn = 0;
    #1;
    chk("rst_mid_busy", busy_a, 1'b0);
    chk("rst_mid_req_vld", mv_a, 1'b0);
    chk("rst_mid_req_addr", maddr_a, 40'h0);
    chk("rst_mid_grant", gv_a, 1'b0);
    chk("rst_mid_data", data_a, 64'h0);
    exp_to = 0; exp_ov = 0; exp_st = 0;
    chk_flags_a();
    @(negedge clk);
    rstn = 1;
    rv_a = 1; rd_a = 32'h7777_7777; exp_st = 1;
    @(negedge clk);
    rv_a = 0;
    chk("a_post_rst_data", data_a, 64'h0);
    chk_flags_a();
    run_txn_a(40'h00_0000_2000, 0, 0, 0, 0, 0, 32'h1357_9BDF, 32'h2468_ACE0);

    // 64-bit beats: minimum turnaround then a few randomized ones
    run_txn_b(40'h00_8000_0004, 0, 0, 64'hDEAD_BEEF_CAFE_BABE);
    for (int n = 0; n < 6; n++) begin
      run_txn_b({8'($urandom), 32'($urandom)}, $urandom_range(2, 0),
                $urandom_range(4, 0), {32'($urandom), 32'($urandom)});
    end
    chk("b_timeout_flag", to_b, 1'b0);
    chk("b_overrun_flag", ov_b, 1'b0);
    chk("b_stray_flag", st_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
